// File: rtl/simon_pkg.sv
// SIMON 64/96 key-schedule constants, state encoding and rotate helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package simon_pkg;

    localparam int SIMON_N = 32;
    localparam int SIMON_M = 3;
    localparam int SIMON_T = 42;

    localparam logic [31:0] SIMON_C = 32'hFFFF_FFFC;

    // z_2 sequence; bit k holds z_2[k], so the LSB is consumed first.
    localparam logic [61:0] SIMON_Z2 =
        62'b11_0011011010_0111111000_1000010100_0110010010_1100000011_1011110101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } simonState_t;

    // Rotate a key word right by a fixed amount.
    function automatic logic [SIMON_N-1:0] rotr(input logic [SIMON_N-1:0] x, input int amt);
        return (x >> amt) | (x << (SIMON_N - amt));
    endfunction

endpackage

// File: rtl/simon_rk_step.sv
// One SIMON 64/96 key-schedule step: rk[i] from rk[i-1], rk[i-3] and z bit.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module simon_rk_step
    import simon_pkg::*;
(
    input  logic [SIMON_N-1:0] rkPrev1,
    input  logic [SIMON_N-1:0] rkPrev3,
    input  logic               zBit,
    output logic [SIMON_N-1:0] rkNext
);

    // For m=3 the mixing is ROR3 ^ ROR4 of the previous word, no ROR1 term on rk[i-3].
    always_comb begin
        rkNext = SIMON_C
               ^ {{(SIMON_N-1){1'b0}}, zBit}
               ^ rkPrev3
               ^ rotr(rkPrev1, 3)
               ^ rotr(rkPrev1, 4);
    end

endmodule

// File: rtl/simon_key_expander.sv
// SIMON 64/96 key expander: loads 3 master words, then generates one round key per clock into a bank.
// Latency: start edge E0, rk[3] at E1, rk[41] and done at E39; bank read port has 1-cycle latency.
// Backpressure: start is ignored while expanding; abort (priority over start) returns to IDLE any cycle.
module simon_key_expander
    import simon_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [SIMON_M*32-1:0]  key_in,
    output logic                   busy,
    output logic                   done,
    output logic                   keys_valid,
    input  logic [5:0]             rd_addr,
    output logic [SIMON_N-1:0]     rd_data
);

    localparam logic [5:0] LAST_IDX = 6'(SIMON_T - 1);
    localparam logic [5:0] NUM_KEYS = 6'(SIMON_T);
    localparam logic [5:0] FIRST_GEN_IDX = 6'(SIMON_M);

    simonState_t        state;
    logic [5:0]         idx;
    logic [61:0]        zReg;

    // Sliding window of the three most recent keys: winOld = rk[i-3], winNew = rk[i-1].
    logic [SIMON_N-1:0] winOld;
    logic [SIMON_N-1:0] winMid;
    logic [SIMON_N-1:0] winNew;

    logic [SIMON_N-1:0] bank [SIMON_T];

    logic [SIMON_N-1:0] rkNext;
    logic [SIMON_N-1:0] key0;
    logic [SIMON_N-1:0] key1;
    logic [SIMON_N-1:0] key2;
    logic               loadKey;
    logic               stepEn;

    assign key0 = key_in[31:0];
    assign key1 = key_in[63:32];
    assign key2 = key_in[95:64];

    // A new expansion may only begin from a quiescent state; abort always wins.
    assign loadKey = start && !abort && ((state == IDLE) || (state == DONE));
    assign stepEn  = !abort && (state == EXPAND);

    simon_rk_step u_step (
        .rkPrev1 (winNew),
        .rkPrev3 (winOld),
        .zBit    (zReg[0]),
        .rkNext  (rkNext)
    );

    // Control FSM, index counter, z sequence and key window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            idx        <= '0;
            zReg       <= SIMON_Z2;
            winOld     <= '0;
            winMid     <= '0;
            winNew     <= '0;
        end else if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            idx        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        winOld     <= key0;
                        winMid     <= key1;
                        winNew     <= key2;
                        zReg       <= SIMON_Z2;
                        idx        <= FIRST_GEN_IDX;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    winOld <= winMid;
                    winMid <= winNew;
                    winNew <= rkNext;
                    zReg   <= zReg >> 1;
                    if (idx == LAST_IDX) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Key bank writes: master words on load, one generated key per expand cycle.
    always_ff @(posedge clk) begin
        if (loadKey) begin
            bank[0] <= key0;
            bank[1] <= key1;
            bank[2] <= key2;
        end else if (stepEn) begin
            bank[idx] <= rkNext;
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_addr < NUM_KEYS) begin
            rd_data <= bank[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_simon_key_expander.sv
// Randomized self-checking bench for simon_key_expander against a round-key schedule model.
// Latency: checks done at E39 and 1-cycle read latency.
// Backpressure: exercises start spam, abort and async reset mid-expansion.
module tb_simon_key_expander;

    localparam int T = 42;

    // z_2 written in the order it is consumed, first bit first.
    string Z2 = "10101111011100000011010010011000101000010001111110010110110011";

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [95:0] key_in;
    logic        busy;
    logic        done;
    logic        keys_valid;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;

    logic [31:0] mdl [T];
    int nCompared   = 0;
    int nMismatched = 0;

    simon_key_expander dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    task automatic buildModel(input logic [95:0] k);
        mdl[0] = k[31:0];
        mdl[1] = k[63:32];
        mdl[2] = k[95:64];
        for (int i = 3; i < T; i++) begin
            mdl[i] = 32'hFFFF_FFFC ^ ((Z2[i-3] == "1") ? 32'd1 : 32'd0)
                   ^ mdl[i-3] ^ rotr(mdl[i-1], 3) ^ rotr(mdl[i-1], 4);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic runExpansion(input logic [95:0] k, input bit spam, input string tag);
        int doneAt;
        buildModel(k);
        start  = 1'b1;
        key_in = k;
        tick();
        start = 1'b0;
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_kv_e0"}, keys_valid, 0);
        doneAt = 0;
        for (int c = 1; c <= 60; c++) begin
            if (spam && c < 38) begin
                start  = 1'($urandom_range(0, 1));
                key_in = {$urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                doneAt = c;
                break;
            end
        end
        start  = 1'b0;
        key_in = k;
        chk({tag, "_done_cycle"}, doneAt, 39);
        chk({tag, "_kv_done"}, keys_valid, 1);
        chk({tag, "_busy_done"}, busy, 0);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_kv_hold"}, keys_valid, 1);
    endtask

    task automatic sweep(input string tag, output logic [31:0] rk3);
        logic [31:0] expd;
        logic [31:0] prevExp;
        prevExp = '0;
        rk3     = '0;
        for (int a = 0; a < 64; a++) begin
            rd_addr = 6'(a);
            #1;
            if (a > 0) chk({tag, "_rd_latency"}, rd_data, prevExp);
            tick();
            expd = (a < T) ? mdl[a] : 32'd0;
            chk({tag, "_rd"}, rd_data, expd);
            if (a == 3) rk3 = rd_data;
            prevExp = expd;
        end
    endtask

    initial begin
        logic [31:0] rk3;
        int          doneSeen;
        logic [95:0] k;

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        key_in  = '0;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_kv", keys_valid, 0);
        chk("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: all-zero key.
        runExpansion(96'h0, 1'b0, "t1");
        sweep("t1", rk3);
        chk("t1_rk3", rk3, 32'hFFFF_FFFD);

        // Test 2: reference key, restarted from DONE.
        runExpansion({32'h13121110, 32'h0b0a0908, 32'h03020100}, 1'b0, "t2");
        sweep("t2", rk3);
        chk("t2_rk3", rk3, 32'hFFAE_9DCE);

        // Test 3: start spammed during expansion must not disturb anything.
        runExpansion({32'h13121110, 32'h0b0a0908, 32'h03020100}, 1'b1, "t3");
        sweep("t3", rk3);

        // Abort in DONE clears keys_valid.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done_kv", keys_valid, 0);

        // Abort beats start in IDLE.
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_prio_busy", busy, 0);

        // Test 4: abort on the edge that would write rk[20].
        k      = {$urandom, $urandom, $urandom};
        start  = 1'b1;
        key_in = k;
        tick();
        start = 1'b0;
        repeat (17) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_kv", keys_valid, 0);
        chk("t4_done", done, 0);
        doneSeen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done || busy) doneSeen++;
        end
        chk("t4_quiet", doneSeen, 0);
        runExpansion({$urandom, $urandom, $urandom}, 1'b0, "t4r");
        sweep("t4r", rk3);

        // Test 5: async reset mid-expansion.
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_kv", keys_valid, 0);
        chk("t5_rd", rd_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t5_busy_hold", busy, 0);
        tick();
        runExpansion({$urandom, $urandom, $urandom}, 1'b1, "t5r");
        sweep("t5r", rk3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
